mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Clk  input  1  single clock; all state updates on posedge Clk.
REQ-002 Rst_n  input  1  asynchronous, active-low reset.
REQ-003 ReqValid  input  1  CPU side has a load/store request pending.
REQ-004 ReqReady  output  1  block accepts a request this cycle.
REQ-005 ReqWrite  input  1  1 = store, 0 = load.
REQ-006 ReqAddr  input  16  word address of the request.
REQ-007 ReqWData  input  16  store data.
REQ-008 RspValid  output  1  response available on RspData.
REQ-009 RspReady  input  1  CPU side consumes the response.
REQ-010 RspData  output  16  load data, or 16'h0000 for a store acknowledge.
REQ-011 RamAddr  output  16  address to the synchronous single-port RAM.
REQ-012 RamWData  output  16  RAM write data.
REQ-013 RamWE  output  1  RAM write strobe, one cycle per store.
REQ-014 RamRData  input  16  RAM read data, valid one cycle after RamAddr is presented.
REQ-015 Switches  input  10  board switches; MMIO read source.
REQ-016 Leds  output  10  board LEDs; registered MMIO write target.

Function
REQ-017 The FSM SHALL have five states: IDLE, RD_ADDR, RD_DATA, WR, RESP.
REQ-018 ReqReady SHALL be 1 only in IDLE; a request is accepted on a posedge with ReqValid && ReqReady.
REQ-019 On accept, ReqAddr, ReqWData and ReqWrite SHALL be latched, and later changes on the Req* inputs SHALL be ignored until the FSM is back in IDLE.
REQ-020 IDLE SHALL go to WR on an accepted store, to RD_ADDR on an accepted load, and otherwise stay in IDLE.
REQ-021 In RD_ADDR, RamAddr SHALL equal the latched address and RamWE SHALL be 0; the next state SHALL be RD_DATA.
REQ-022 In RD_DATA, the read source (RamRData or MMIO) SHALL be captured into RspData; the next state SHALL be RESP.
REQ-023 In WR, RamWE SHALL be 1 for exactly one cycle with the latched address and data, unless the address is MMIO; the next state SHALL be RESP.
REQ-024 A store SHALL load RspData with 16'h0000 when it enters RESP.
REQ-025 In RESP, RspValid SHALL be 1 and RspData SHALL be held stable until RspReady is 1; then the FSM SHALL return to IDLE.
REQ-026 Load latency SHALL be fixed: RspValid rises 3 cycles after the accept edge; for a store it rises 2 cycles after.
REQ-027 No new request SHALL be accepted in the cycle a response is consumed; the minimum request spacing is one IDLE cycle.
REQ-028 RamWE SHALL be 0 in every state except WR.
REQ-029 RamAddr and RamWData SHALL hold the latched values outside IDLE.

Reset
REQ-030 While Rst_n is 0, the block SHALL enter IDLE immediately, independent of Clk.
REQ-031 Reset values SHALL be: ReqReady 0 during reset, then 1 in IDLE; RspValid 0; RspData 0; RamWE 0; RamAddr 0; RamWData 0; Leds 0; cycle counter 0.
REQ-032 A reset in mid-operation SHALL drop the pending request without completing any RAM write.

Configuration
REQ-033 The macro MEM_RESP_MMIO_EN SHALL select memory-mapped I/O handling.
REQ-034 With MEM_RESP_MMIO_EN defined, the block SHALL decode two MMIO addresses:
- 16'hFFFE: a read returns {6'b0, Switches}; a write sets Leds to the latched data [9:0].
- 16'hFFFF: a read returns a 16-bit free-running cycle counter that wraps from 16'hFFFF to 0; a write is ignored.
- Neither MMIO address SHALL ever assert RamWE.
REQ-035 With MEM_RESP_MMIO_EN undefined, all addresses SHALL go to RAM, Leds SHALL be tied to 0, and no counter SHALL be instantiated.

Verification
REQ-036 Store 16'hBEEF to 16'h0010 with RspReady=1 -> RamWE=1 for one cycle with RamAddr=0010 and RamWData=BEEF; RspValid 2 cycles after accept; RspData=0000.
REQ-037 Load from 16'h0010 after REQ-036, with the RAM model returning BEEF -> RspValid 3 cycles after accept; RspData=BEEF.
REQ-038 Load with RspReady held 0 for 4 cycles -> RspValid and RspData stay stable and ReqReady stays 0; the FSM returns to IDLE the cycle after RspReady=1.
REQ-039 With MEM_RESP_MMIO_EN: store 16'h03A5 to FFFE -> Leds=10'h3A5 and RamWE never asserted; with Switches=10'h155, a load from FFFE -> RspData=0155; two FFFF loads 10 cycles apart -> values differ by 10 modulo 2^16.
REQ-040 Assert Rst_n=0 during WR or RD_DATA -> RamWE=0 and RspValid=0 immediately; after release, IDLE with ReqReady=1 and no response issued for the dropped request.

Source files
------------

// File: rtl/mem_responder.sv
// Single-request memory responder: accepts one CPU load/store, drives a synchronous RAM, returns one response.
// Define MEM_RESP_MMIO_EN to decode 16'hFFFE (switches/LEDs) and 16'hFFFF (cycle counter) as MMIO.
module mem_responder (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_data,
   output logic [15:0] ram_addr,
   output logic [15:0] ram_wdata,
   output logic        ram_we,
   input  logic [15:0] ram_rdata,
   input  logic [9:0]  switches,
   output logic [9:0]  leds
);

   typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, RESP} state_t;

   state_t      state, state_nxt;
   logic        accept;
   logic        is_mmio;
   logic [15:0] rd_src;

   // Held in reset while rst_n is low so nothing is accepted before the FSM is live.
   assign req_ready = rst_n && (state == IDLE);
   assign accept    = req_valid && req_ready;
   assign rsp_valid = (state == RESP);
   assign ram_we    = (state == WR) && !is_mmio;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: next state defaults to the current state first, so no path through the case infers a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = req_write ? WR : RD_ADDR;
         RD_ADDR: state_nxt = RD_DATA;
         RD_DATA: state_nxt = RESP;
         WR:      state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Request fields are captured only on accept; the load/store choice lives in the state itself.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ram_addr  <= '0;
         ram_wdata <= '0;
         rsp_data  <= '0;
      end else begin
         if (accept) begin
            ram_addr  <= req_addr;
            ram_wdata <= req_wdata;
         end
         if (state == RD_DATA) rsp_data <= rd_src;
         else if (state == WR) rsp_data <= '0;
      end
   end

`ifdef MEM_RESP_MMIO_EN
   localparam logic [15:0] ADDR_IO  = 16'hFFFE;
   localparam logic [15:0] ADDR_CNT = 16'hFFFF;

   logic [15:0] cycle_cnt;
   logic [9:0]  led_q;

   assign is_mmio = (ram_addr == ADDR_IO) || (ram_addr == ADDR_CNT);
   assign leds    = led_q;

   always_comb begin
      rd_src = ram_rdata;
      if (ram_addr == ADDR_IO)       rd_src = {6'b0, switches};
      else if (ram_addr == ADDR_CNT) rd_src = cycle_cnt;
   end

   // Counter wraps naturally at 16 bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cycle_cnt <= '0;
      else        cycle_cnt <= cycle_cnt + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                 led_q <= '0;
      else if (state == WR && ram_addr == ADDR_IO) led_q <= ram_wdata[9:0];
   end
`else
   logic unused_switches;

   assign is_mmio         = 1'b0;
   assign rd_src          = ram_rdata;
   assign leds            = '0;
   assign unused_switches = ^switches;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed testbench for mem_responder with a one-cycle-latency RAM model.
// Covers MMIO behaviour when built with MEM_RESP_MMIO_EN, RAM fall-through otherwise.
module tb_mem_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_write;
   logic [15:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_ready;
   logic [15:0] rsp_data, ram_addr, ram_wdata, ram_rdata;
   logic        ram_we;
   logic [9:0]  switches, leds;

   int vectors = 0;
   int miscompares = 0;
   int we_count = 0;
   int tb_cyc = 0;

   logic [15:0] ram_mem [0:65535];

   mem_responder dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
      .switches(switches), .leds(leds)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      ram_rdata <= ram_mem[ram_addr];
   end

   always @(posedge clk) begin
      tb_cyc <= tb_cyc + 1;
      if (ram_we) we_count <= we_count + 1;
   end

   // Results of the last run_req call.
   logic        r_rdy, r_we1, r_idle;
   logic [15:0] r_addr1, r_wdata1, r_data;
   int          r_lat, r_acc;

   // Issues one request, scrambles the Req inputs after accept, and measures the response.
   task automatic run_req(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                          input int at_cyc);
      @(negedge clk);
      rsp_ready = 1'b1;
      if (at_cyc >= 0)
         for (int g = 0; g < 64 && tb_cyc < at_cyc; g++) @(negedge clk);
      req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
      r_rdy = req_ready;
      r_acc = tb_cyc;
      @(negedge clk);
      req_valid = 1'b0; req_write = ~wr; req_addr = 16'h7777; req_wdata = 16'h0BAD;
      r_we1 = ram_we; r_addr1 = ram_addr; r_wdata1 = ram_wdata;
      r_lat = 1;
      while (rsp_valid !== 1'b1 && r_lat < 8) begin
         @(negedge clk);
         r_lat++;
      end
      r_data = rsp_data;
      @(negedge clk);
      r_idle = (rsp_valid === 1'b0) && (req_ready === 1'b1);
   endtask

   task automatic test_reset;
      #2;
      vectors++;
      if ({req_ready, rsp_valid, ram_we} !== 3'b000 || rsp_data !== 16'h0 ||
          ram_addr !== 16'h0 || ram_wdata !== 16'h0 || leds !== 10'h0) begin
         miscompares++;
         $display("FAIL reset_values: ready=%b valid=%b we=%b data=%h addr=%h wdata=%h leds=%h expected all zero",
                  req_ready, rsp_valid, ram_we, rsp_data, ram_addr, ram_wdata, leds);
      end
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      vectors++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_release: ready=%b valid=%b expected ready=1 valid=0", req_ready, rsp_valid);
      end
   endtask

   task automatic test_store;
      int we0;
      we0 = we_count;
      run_req(1'b1, 16'h0010, 16'hBEEF, -1);
      vectors++;
      if (r_rdy !== 1'b1 || r_we1 !== 1'b1 || r_addr1 !== 16'h0010 || r_wdata1 !== 16'hBEEF) begin
         miscompares++;
         $display("FAIL store_wr: ready=%b we=%b addr=%h wdata=%h expected 1 1 0010 BEEF", r_rdy, r_we1, r_addr1, r_wdata1);
      end
      vectors++;
      if (r_lat !== 2 || r_data !== 16'h0000) begin
         miscompares++;
         $display("FAIL store_rsp: latency=%0d data=%h expected 2 0000", r_lat, r_data);
      end
      vectors++;
      if (we_count - we0 !== 1 || r_idle !== 1'b1) begin
         miscompares++;
         $display("FAIL store_we_once: we pulses=%0d idle=%b expected 1 1", we_count - we0, r_idle);
      end
   endtask

   task automatic test_load;
      int we0;
      we0 = we_count;
      run_req(1'b0, 16'h0010, 16'h0000, -1);
      vectors++;
      if (r_we1 !== 1'b0 || r_addr1 !== 16'h0010) begin
         miscompares++;
         $display("FAIL load_rd_addr: we=%b addr=%h expected 0 0010", r_we1, r_addr1);
      end
      vectors++;
      if (r_lat !== 3 || r_data !== 16'hBEEF) begin
         miscompares++;
         $display("FAIL load_rsp: latency=%0d data=%h expected 3 BEEF", r_lat, r_data);
      end
      vectors++;
      if (we_count != we0 || r_idle !== 1'b1) begin
         miscompares++;
         $display("FAIL load_no_write: we pulses=%0d idle=%b expected 0 1", we_count - we0, r_idle);
      end
   endtask

   task automatic test_hold;
      int  n;
      int  we0;
      logic bad;
      we0 = we_count;
      @(negedge clk);
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0010;
      @(negedge clk);
      req_valid = 1'b0;
      n = 1;
      while (rsp_valid !== 1'b1 && n < 8) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (n !== 3 || rsp_data !== 16'hBEEF) begin
         miscompares++;
         $display("FAIL hold_first: latency=%0d data=%h expected 3 BEEF", n, rsp_data);
      end
      // Try to sneak in a store while the response is stalled.
      req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0040; req_wdata = 16'h4444;
      bad = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b1 || rsp_data !== 16'hBEEF || req_ready !== 1'b0) bad = 1'b1;
      end
      vectors++;
      if (bad !== 1'b0) begin
         miscompares++;
         $display("FAIL hold_stable: valid=%b data=%h ready=%b expected 1 BEEF 0", rsp_valid, rsp_data, req_ready);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || we_count != we0) begin
         miscompares++;
         $display("FAIL hold_release: valid=%b ready=%b we pulses=%0d expected 0 1 0", rsp_valid, req_ready, we_count - we0);
      end
   endtask

   task automatic test_back_to_back;
      logic [6:0] pat;
      int we0;
      we0 = we_count;
      @(negedge clk);
      rsp_ready = 1'b1;
      req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0030; req_wdata = 16'h1111;
      pat[0] = req_ready;
      for (int k = 1; k < 7; k++) begin
         @(negedge clk);
         pat[k] = req_ready;
      end
      req_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (pat !== 7'b1001001 || we_count - we0 !== 2) begin
         miscompares++;
         $display("FAIL back_to_back: ready pattern=%b we pulses=%0d expected 1001001 2", pat, we_count - we0);
      end
   endtask

   task automatic test_reset_mid_write;
      int  we0;
      logic seen;
      run_req(1'b1, 16'h0020, 16'h5A5A, -1);
      vectors++;
      if (r_lat !== 2 || r_data !== 16'h0000) begin
         miscompares++;
         $display("FAIL preload_store: latency=%0d data=%h expected 2 0000", r_lat, r_data);
      end
      we0 = we_count;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0020; req_wdata = 16'h1234;
      @(negedge clk);
      req_valid = 1'b0;
      vectors++;
      if (ram_we !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_write_pre: we=%b expected 1", ram_we);
      end
      #1 rst_n = 1'b0;
      #1;
      vectors++;
      if (ram_we !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_write_reset: we=%b valid=%b ready=%b expected 0 0 0", ram_we, rsp_valid, req_ready);
      end
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0 || req_ready !== 1'b1) seen = 1'b1;
      end
      vectors++;
      if (seen !== 1'b0 || we_count != we0) begin
         miscompares++;
         $display("FAIL mid_write_dropped: stray=%b we pulses=%0d expected 0 0", seen, we_count - we0);
      end
      run_req(1'b0, 16'h0020, 16'h0000, -1);
      vectors++;
      if (r_lat !== 3 || r_data !== 16'h5A5A) begin
         miscompares++;
         $display("FAIL mid_write_ram: latency=%0d data=%h expected 3 5A5A", r_lat, r_data);
      end
   endtask

   task automatic test_reset_mid_read;
      logic seen;
      @(negedge clk);
      rsp_ready = 1'b1;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0010;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      vectors++;
      if (rsp_valid !== 1'b0 || rsp_data !== 16'h0000 || ram_we !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_read_reset: valid=%b data=%h we=%b expected 0 0000 0", rsp_valid, rsp_data, ram_we);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0 || req_ready !== 1'b1) seen = 1'b1;
      end
      vectors++;
      if (seen !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_read_dropped: stray response or not idle, got %b expected 0", seen);
      end
   endtask

   task automatic test_mmio;
      int we0;
`ifdef MEM_RESP_MMIO_EN
      logic [15:0] c1, diff;
      int acc1;
      we0 = we_count;
      run_req(1'b1, 16'hFFFE, 16'h03A5, -1);
      vectors++;
      if (leds !== 10'h3A5 || we_count != we0 || r_lat !== 2 || r_data !== 16'h0000) begin
         miscompares++;
         $display("FAIL mmio_led_store: leds=%h we pulses=%0d latency=%0d data=%h expected 3A5 0 2 0000",
                  leds, we_count - we0, r_lat, r_data);
      end
      run_req(1'b1, 16'hFFFF, 16'h00FF, -1);
      vectors++;
      if (leds !== 10'h3A5 || we_count != we0) begin
         miscompares++;
         $display("FAIL mmio_cnt_store: leds=%h we pulses=%0d expected 3A5 0", leds, we_count - we0);
      end
      switches = 10'h155;
      run_req(1'b0, 16'hFFFE, 16'h0000, -1);
      vectors++;
      if (r_lat !== 3 || r_data !== 16'h0155) begin
         miscompares++;
         $display("FAIL mmio_switch_load: latency=%0d data=%h expected 3 0155", r_lat, r_data);
      end
      run_req(1'b0, 16'hFFFF, 16'h0000, -1);
      c1 = r_data;
      acc1 = r_acc;
      run_req(1'b0, 16'hFFFF, 16'h0000, acc1 + 10);
      diff = r_data - c1;
      vectors++;
      if (diff !== 16'd10 || r_acc - acc1 != 10) begin
         miscompares++;
         $display("FAIL mmio_counter: delta=%0d spacing=%0d expected 10 10", diff, r_acc - acc1);
      end
`else
      we0 = we_count;
      run_req(1'b1, 16'hFFFE, 16'h03A5, -1);
      vectors++;
      if (leds !== 10'h000 || we_count - we0 !== 1) begin
         miscompares++;
         $display("FAIL ram_fffe_store: leds=%h we pulses=%0d expected 000 1", leds, we_count - we0);
      end
      switches = 10'h155;
      run_req(1'b0, 16'hFFFE, 16'h0000, -1);
      vectors++;
      if (r_lat !== 3 || r_data !== 16'h03A5) begin
         miscompares++;
         $display("FAIL ram_fffe_load: latency=%0d data=%h expected 3 03A5", r_lat, r_data);
      end
`endif
   endtask

   initial begin
      rst_n = 1'b0;
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      rsp_ready = 1'b1; switches = '0;
      test_reset();
      test_store();
      test_load();
      test_hold();
      test_back_to_back();
      test_reset_mid_write();
      test_reset_mid_read();
      test_mmio();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, expected finish before 200000");
      $fatal(1, "timeout");
   end

endmodule
